// File: rtl/raster_tile_buffer_pkg.sv
// Types shared by the tile buffer, its interface and its storage.
package raster_tile_buffer_pkg;
`include "raster_defines.svh"

  typedef enum logic [1:0] {
    CLEAR,
    ACCEPT,
    FLUSH
  } tile_state_t;

  typedef logic [`COLOR_BITS-1:0] color_t;

  // Integer fragment position lies inside a w x h tile.
  function automatic logic in_tile(input logic signed [`COORD_BITS-1:0] x,
                                   input logic signed [`COORD_BITS-1:0] y,
                                   input int w, input int h);
    return (int'(x) >= 0) && (int'(x) < w) && (int'(y) >= 0) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/raster_tile_buffer_if.sv
// Fragment input, flush request and output word stream of the tile buffer.
`include "raster_defines.svh"

interface raster_tile_buffer_if #(parameter int IDX_W = 8);
  import raster_tile_buffer_pkg::*;

  logic                          vld_in;
  logic                          rdy_in;
  coord_2d_t                     pixel_in;
  logic [`COLOR_BITS-1:0]        color_in;
  logic                          flush_req;
  logic [`TILE_COLUMNS_BITS-1:0] tile_x_in;
  logic [`TILE_ROWS_BITS-1:0]    tile_y_in;
  logic                          vld_out;
  logic                          rdy_out;
  logic [`COLOR_BITS-1:0]        color_out;
  logic [IDX_W-1:0]              pix_idx_out;
  logic                          last_out;
  logic [`TILE_COLUMNS_BITS-1:0] tile_x_out;
  logic [`TILE_ROWS_BITS-1:0]    tile_y_out;
  logic                          busy;

  modport master (
    output vld_in, pixel_in, color_in, flush_req, tile_x_in, tile_y_in, rdy_out,
    input  rdy_in, vld_out, color_out, pix_idx_out, last_out, tile_x_out, tile_y_out, busy
  );

  modport slave (
    input  vld_in, pixel_in, color_in, flush_req, tile_x_in, tile_y_in, rdy_out,
    output rdy_in, vld_out, color_out, pix_idx_out, last_out, tile_x_out, tile_y_out, busy
  );
endinterface

// File: rtl/raster_defines.svh
// Shared raster-pipeline widths and the fixed-point fragment coordinate type.
`ifndef RASTER_DEFINES_SVH
`define RASTER_DEFINES_SVH

`define COLOR_BITS 8
`define FX_FRAC_BITS 4
`define COORD_BITS 16
`define TILE_COLUMNS_BITS 8
`define TILE_ROWS_BITS 8

typedef struct packed {
  logic [`COORD_BITS-1:0] x;
  logic [`COORD_BITS-1:0] y;
} coord_2d_t;

`endif

// File: rtl/raster_tile_buffer_mem.sv
// Tile colour storage: one synchronous write port, one registered read port.
`include "raster_defines.svh"

module raster_tile_mem
  import raster_tile_buffer_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = `COLOR_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/raster_tile_buffer.sv
// Tile colour buffer: clears itself, accepts fragments, then streams the tile
// out row-major while clearing each entry behind the stream.
`include "raster_defines.svh"

module raster_tile_buffer
  import raster_tile_buffer_pkg::*;
#(
  parameter int                     TILE_W      = 16,
  parameter int                     TILE_H      = 16,
  parameter logic [`COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
  input logic               clk,
  input logic               rst_n,
  raster_tile_buffer_if.slave bus
);

  localparam int N     = TILE_W * TILE_H;
  localparam int IDX_W = $clog2(N);
  localparam int XW    = $clog2(TILE_W);
  localparam int YW    = $clog2(TILE_H);

  tile_state_t                   state, state_nxt;
  logic [IDX_W-1:0]              clr_cnt;
  logic [IDX_W-1:0]              out_idx;
  logic                          primed;
  logic [`TILE_COLUMNS_BITS-1:0] tile_x_q;
  logic [`TILE_ROWS_BITS-1:0]    tile_y_q;

  logic signed [`COORD_BITS-1:0] x_int, y_int;
  logic                          frag_hit;
  logic [IDX_W-1:0]              frag_addr;
  logic                          fire;

  logic                          mem_we;
  logic [IDX_W-1:0]              mem_waddr, mem_raddr;
  logic [`COLOR_BITS-1:0]        mem_wdata, mem_rdata;

  assign x_int     = $signed(bus.pixel_in.x) >>> `FX_FRAC_BITS;
  assign y_int     = $signed(bus.pixel_in.y) >>> `FX_FRAC_BITS;
  assign frag_hit  = in_tile(x_int, y_int, TILE_W, TILE_H);
  assign frag_addr = {y_int[YW-1:0], x_int[XW-1:0]};
  assign fire      = bus.vld_out && bus.rdy_out;

  // The read address always targets the word shown next cycle, so the
  // registered RAM output stays put during a stall and advances without a bubble.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = frag_addr;
    mem_wdata = bus.color_in;
    mem_raddr = out_idx;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = CLEAR_COLOR;
        if (clr_cnt == IDX_W'(N - 1)) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        mem_we = bus.vld_in && frag_hit;
        if (bus.flush_req) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (fire) begin
          mem_we    = 1'b1;
          mem_waddr = out_idx;
          mem_wdata = CLEAR_COLOR;
          mem_raddr = out_idx + 1'b1;
          if (out_idx == IDX_W'(N - 1)) state_nxt = ACCEPT;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      out_idx  <= '0;
      primed   <= 1'b0;
      tile_x_q <= '0;
      tile_y_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == FLUSH && fire) out_idx <= out_idx + 1'b1;
      // First flush cycle only primes the read of entry 0.
      primed <= (state == FLUSH) && (state_nxt == FLUSH);
      if (state == ACCEPT && bus.flush_req) begin
        tile_x_q <= bus.tile_x_in;
        tile_y_q <= bus.tile_y_in;
      end
    end
  end

  assign bus.rdy_in      = (state == ACCEPT);
  assign bus.busy        = (state != ACCEPT);
  assign bus.vld_out     = (state == FLUSH) && primed;
  assign bus.color_out   = bus.vld_out ? mem_rdata : '0;
  assign bus.pix_idx_out = out_idx;
  assign bus.last_out    = bus.vld_out && (out_idx == IDX_W'(N - 1));
  assign bus.tile_x_out  = tile_x_q;
  assign bus.tile_y_out  = tile_y_q;

  raster_tile_mem #(
    .DEPTH (N),
    .AW    (IDX_W),
    .DW    (`COLOR_BITS)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/raster_tile_buffer.md
RASTER_TILE_BUFFER -- requirements
Module: raster_tile_buffer

Interface
REQ-001 SHALL have parameter TILE_W, default 16, tile width in pixels (power of 2).
REQ-002 SHALL have parameter TILE_H, default 16, tile height in pixels (power of 2).
REQ-003 SHALL have parameter CLEAR_COLOR, default 0, value written to every entry on clear.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk input 1 (clock), rst_n input 1 (reset).
REQ-005 SHALL have: vld_in input 1, fragment valid from raster stage.
REQ-006 SHALL have: rdy_in output 1, buffer can accept a fragment.
REQ-007 SHALL have: pixel_in input coord_2d_t, fixed-point tile-local fragment position.
REQ-008 SHALL have: color_in input `COLOR_BITS, fragment color.
REQ-009 SHALL have: flush_req input 1, request to stream out the tile.
REQ-010 SHALL have: tile_x_in input `TILE_COLUMNS_BITS and tile_y_in input `TILE_ROWS_BITS, tile id, sampled with flush_req.
REQ-011 SHALL have: vld_out output 1, rdy_out input 1, output word handshake.
REQ-012 SHALL have: color_out output `COLOR_BITS, pix_idx_out output $clog2(TILE_W*TILE_H), last_out output 1.
REQ-013 SHALL have: tile_x_out/tile_y_out outputs (same widths as inputs), and busy output 1.

Function
REQ-014 SHALL implement FSM states CLEAR, ACCEPT, FLUSH.
REQ-015 SHALL enter CLEAR on reset, write CLEAR_COLOR to entries 0..N-1 (N=TILE_W*TILE_H), one per cycle, then go to ACCEPT (N cycles).
REQ-016 SHALL drive rdy_in=1 only in ACCEPT; busy=1 in CLEAR and FLUSH.
REQ-017 SHALL, on vld_in&&rdy_in, take x=pixel_in.x>>>`FX_FRAC_BITS, y=pixel_in.y>>>`FX_FRAC_BITS (signed integer part).
REQ-018 SHALL write color_in to entry y*TILE_W+x when 0<=x<TILE_W and 0<=y<TILE_H; out-of-range fragments are accepted and discarded.
REQ-019 SHALL, later write to the same entry, overwrite (last-writer wins; no depth test here).
REQ-020 SHALL sample flush_req only in ACCEPT; flush_req in CLEAR/FLUSH is ignored.
REQ-021 SHALL, on flush_req in ACCEPT, latch tile_x_in/tile_y_in into tile_x_out/tile_y_out and enter FLUSH next cycle.
REQ-022 SHALL, when a fragment handshake and flush_req coincide, commit the write first so the flush includes it.
REQ-023 SHALL in FLUSH emit N words, pix_idx_out 0..N-1 in order (row-major, y outer), with color_out = stored entry.
REQ-024 SHALL hold vld_out, color_out, pix_idx_out, last_out stable while vld_out&&!rdy_out.
REQ-025 SHALL advance one word per vld_out&&rdy_out; sustained throughput 1 word/cycle with rdy_out held high.
REQ-026 SHALL assert last_out only with pix_idx_out=N-1.
REQ-027 SHALL write CLEAR_COLOR to each entry once its word is handshaken, so the tile is clear after flush.
REQ-028 SHALL return to ACCEPT the cycle after the last handshake; first vld_out no more than 2 cycles after flush_req.

Reset
REQ-029 SHALL, while rst_n=0, force rdy_in=0, vld_out=0, last_out=0, busy=1, color_out=0, pix_idx_out=0, tile_x_out=0, tile_y_out=0, state=CLEAR, clear counter=0.
REQ-030 SHALL, on reset mid-FLUSH or mid-CLEAR, abandon the operation and restart the full CLEAR sequence; no partial stream resumes.

Structure
REQ-031 SHALL take coord_2d_t, `COLOR_BITS, `FX_FRAC_BITS, `TILE_COLUMNS_BITS, `TILE_ROWS_BITS from raster_defines.svh; the FSM state enum belongs in the shared package.
REQ-032 SHALL instantiate one sub-module, raster_tile_mem: N x `COLOR_BITS, one synchronous write port, one synchronous read port, 1-cycle read latency; output skid register absorbs latency under backpressure.

Verification
REQ-033 SHALL cover reset: rdy_in=0 for exactly 256 cycles (16x16), then 1; vld_out=0 throughout.
REQ-034 SHALL cover write/flush: fragment (3,4) color 5, flush tile (2,0), rdy_out=1 -> 256 words, index 67 =5, all others 0, last_out at index 255, tile_x_out=2.
REQ-035 SHALL cover re-flush: second flush immediately after -> all 256 words = CLEAR_COLOR.
REQ-036 SHALL cover backpressure: rdy_out random 50% -> each index appears once, in order, outputs unchanged while stalled.
REQ-037 SHALL cover bounds/overlap: fragments (-1,2),(16,0),(0,16) discarded; (5,5) written 7 then 9 -> flush shows 9 at index 85.
REQ-038 SHALL cover coincidence/reset: write (0,0) color 3 with flush_req same cycle -> index 0 =3; rst_n low at word 100 -> vld_out=0, 256-cycle CLEAR re-runs.
